// File: rtl/timer_device_pkg.sv
// Shared constants for the countdown timer: register offsets, CTRL bit
// positions, mode codes and FSM state encodings.
package timer_device_pkg;

    // Word offsets on the bridge (bus address bits [3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;

    // Mode codes; 10 and 11 fall back to one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Only the exact auto-reload code reloads; every other code is one-shot.
    function automatic logic is_reload(input logic [3:0] ctrl);
        return ctrl[CTRL_MODE_LO +: 2] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_device.sv
// Programmable countdown timer with three word registers (CTRL, PRESET,
// COUNT) and a maskable interrupt request feeding CP0 HWInt[2].
module timer_device
    import timer_device_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;

    // Next-state logic: FSM first, then bus writes so a CTRL write overrides
    // any same-cycle FSM update of Enable or the interrupt flag.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'd0) begin
                    state_d = ST_INT;
                    irq_d   = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_q)) begin
                    // Auto-reload: flag is visible only for the INT cycle
                    state_d = ST_LOAD;
                    irq_d   = 1'b0;
                end else begin
                    // One-shot: stop, leave the flag up until software acks
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (WE) begin
            case (Addr)
                ADDR_CTRL: begin
                    ctrl_d = DIn[3:0];
                    irq_d  = 1'b0;
                end
                ADDR_PRESET: preset_d = DIn;
                default: ;  // COUNT is read-only, offset 3 unused
            endcase
        end
    end

    // State and register file, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= PRESET_RST;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Unpipelined read mux
    always_comb begin
        DOut = 32'd0;
        case (Addr)
            ADDR_CTRL:   DOut = {28'd0, ctrl_q};
            ADDR_PRESET: DOut = preset_q;
            ADDR_COUNT:  DOut = count_q;
            default:     DOut = 32'd0;
        endcase
    end

    // Interrupt request straight from registers
    always_comb IRQ = irq_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: a register-access vector table followed
// by hand-written multi-cycle sequences for counting, IRQ and corner cases.
module tb_timer_device;

    localparam logic [31:0] P_RST = 32'hC0DE_0042;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  Addr = 2'd0;
    logic        WE = 1'b0;
    logic [31:0] DIn = 32'd0;
    logic [31:0] DOut;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    timer_device #(.PRESET_RST(P_RST)) dut (
        .clk (clk),
        .rst (rst),
        .Addr(Addr),
        .WE  (WE),
        .DIn (DIn),
        .DOut(DOut),
        .IRQ (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        WE   = 1'b0;
        #1;
        d = DOut;
    endtask

    // Edges until IRQ is seen high, capped at bound
    task automatic wait_irq(input int bound, output int n);
        n = 0;
        while (!IRQ && n < bound) begin
            tick();
            n++;
        end
    endtask

    // Edges until COUNT reads target, capped at bound
    task automatic wait_count(input logic [31:0] target, input int bound, output int n);
        n = 0;
        Addr = 2'd2;
        #1;
        while (DOut !== target && n < bound) begin
            tick();
            n++;
            #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        int n;
        int ar_cnt[6];
        logic seen;

        ar_cnt = '{0, 0, 3, 2, 1, 0};

        //            addr  we    din            exp_dout       irq
        vt[0]  = '{2'd0, 1'b0, 32'h0,          32'h0,          1'b0};
        vt[1]  = '{2'd1, 1'b0, 32'h0,          P_RST,          1'b0};
        vt[2]  = '{2'd2, 1'b0, 32'h0,          32'h0,          1'b0};
        vt[3]  = '{2'd3, 1'b0, 32'h0,          32'h0,          1'b0};
        vt[4]  = '{2'd1, 1'b1, 32'hAAAA_5555,  P_RST,          1'b0};
        vt[5]  = '{2'd1, 1'b0, 32'h0,          32'hAAAA_5555,  1'b0};
        vt[6]  = '{2'd2, 1'b1, 32'h1234_5678,  32'h0,          1'b0};
        vt[7]  = '{2'd2, 1'b0, 32'h0,          32'h0,          1'b0};
        vt[8]  = '{2'd3, 1'b1, 32'hFFFF_FFFF,  32'h0,          1'b0};
        vt[9]  = '{2'd3, 1'b0, 32'h0,          32'h0,          1'b0};
        vt[10] = '{2'd0, 1'b1, 32'hFFFF_FFF6,  32'h0,          1'b0};
        vt[11] = '{2'd0, 1'b0, 32'h0,          32'h0000_0006,  1'b0};
        vt[12] = '{2'd0, 1'b1, 32'h0,          32'h0000_0006,  1'b0};
        vt[13] = '{2'd0, 1'b0, 32'h0,          32'h0,          1'b0};
        vt[14] = '{2'd1, 1'b0, 32'h0,          32'hAAAA_5555,  1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Register access table (Enable never set, so the FSM stays idle)
        for (int i = 0; i < 15; i++) begin
            Addr = vt[i].addr;
            WE   = vt[i].we;
            DIn  = vt[i].din;
            #1;
            chk($sformatf("vec%0d_dout", i), DOut, vt[i].exp_dout);
            chk($sformatf("vec%0d_irq", i), {31'd0, IRQ}, {31'd0, vt[i].exp_irq});
            tick();
        end
        WE = 1'b0;

        // One-shot, PRESET=5: IRQ at edge 8, Enable self-clears, flag held
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        wait_irq(20, n);
        chk("os_latency", n, 8);
        tick();
        rd(2'd0, d);
        chk("os_ctrl_after", d, 32'h8);
        chk("os_irq_held", {31'd0, IRQ}, 32'd1);
        repeat (3) tick();
        chk("os_irq_held2", {31'd0, IRQ}, 32'd1);
        rd(2'd2, d);
        chk("os_count0", d, 32'd0);
        wr(2'd0, 32'h0);
        chk("os_ack_irq", {31'd0, IRQ}, 32'd0);

        // Auto-reload, PRESET=3: one-cycle pulse every 6 edges
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        wait_irq(20, n);
        chk("ar_first", n, 6);
        for (int k = 0; k < 12; k++) begin
            rd(2'd2, d);
            chk($sformatf("ar_irq_k%0d", k), {31'd0, IRQ}, (k % 6 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("ar_cnt_k%0d", k), d, ar_cnt[k % 6]);
            tick();
        end
        wr(2'd0, 32'h0);
        repeat (5) tick();

        // Masked interrupt, PRESET=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            seen |= IRQ;
        end
        chk("mask_no_irq", {31'd0, seen}, 32'd0);
        rd(2'd0, d);
        chk("mask_en_clear", d, 32'h0);
        rd(2'd2, d);
        chk("mask_count0", d, 32'd0);
        wr(2'd0, 32'h8);
        rd(2'd0, d);
        chk("mask_ctrl8", d, 32'h8);
        chk("mask_irq_after_im", {31'd0, IRQ}, 32'd0);
        repeat (2) tick();
        chk("mask_irq_later", {31'd0, IRQ}, 32'd0);

        // Disable mid-count, re-enable, PRESET change while counting
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        wait_count(32'd11, 60, n);
        chk("dis_reach11", {31'd0, (n < 60)}, 32'd1);
        wr(2'd0, 32'h8);
        rd(2'd2, d);
        chk("dis_count10", d, 32'd10);
        repeat (5) tick();
        rd(2'd2, d);
        chk("dis_hold10", d, 32'd10);
        chk("dis_no_irq", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'h9);
        repeat (2) tick();
        rd(2'd2, d);
        chk("reen_reload", d, 32'd20);
        wr(2'd1, 32'd9);
        rd(2'd2, d);
        chk("preset_no_effect", d, 32'd19);
        wait_irq(60, n);
        chk("reen_latency", n + 3, 23);
        rd(2'd2, d);
        chk("reen_count0", d, 32'd0);
        tick();
        rd(2'd0, d);
        chk("reen_ctrl8", d, 32'h8);
        wr(2'd0, 32'h9);
        wait_irq(40, n);
        chk("preset9_latency", n, 12);
        wr(2'd0, 32'h0);
        repeat (2) tick();

        // PRESET=0 and a CTRL write colliding with the INT transition
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        wait_irq(20, n);
        chk("p0_latency", n, 3);
        wr(2'd0, 32'hD);
        rd(2'd0, d);
        chk("coll_ctrl", d, 32'hD);
        chk("coll_irq_clr", {31'd0, IRQ}, 32'd0);
        wait_irq(20, n);
        chk("coll_restart", n, 3);
        tick();
        rd(2'd0, d);
        chk("mode10_oneshot", d, 32'hC);
        wr(2'd0, 32'h0);
        repeat (2) tick();

        // Asynchronous reset mid-count at COUNT=7
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        wait_count(32'd7, 60, n);
        chk("rst_reach7", {31'd0, (n < 60)}, 32'd1);
        rst = 1'b0;
        rd(2'd2, d);
        chk("rst_count", d, 32'd0);
        rd(2'd0, d);
        chk("rst_ctrl", d, 32'd0);
        rd(2'd1, d);
        chk("rst_preset", d, P_RST);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        rd(2'd2, d);
        chk("rst_idle_count", d, 32'd0);

        // Reset while IRQ is high drops it immediately
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        repeat (3) tick();
        chk("rst_pre_irq", {31'd0, IRQ}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_irq_drop", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
